// File: rtl/bsg_manycore_mem_responder_if.sv
// Request/response bundle between a manycore endpoint rx side and the scratchpad responder.
// Signal names keep the endpoint's _i/_o suffixes as seen from the responder.
interface bsg_manycore_mem_responder_if #(
  parameter int addr_width_p = 28,
  parameter int data_width_p = 32
);
  logic                    in_v_i;
  logic                    in_we_i;
  logic [addr_width_p-1:0] in_addr_i;
  logic [data_width_p-1:0] in_data_i;
  logic [3:0]              in_mask_i;
  logic [1:0]              in_amo_op_i;
  logic                    in_yumi_o;
  logic                    returning_v_o;
  logic [data_width_p-1:0] returning_data_o;
  logic                    err_o;

  modport master (
    output in_v_i, in_we_i, in_addr_i, in_data_i, in_mask_i, in_amo_op_i,
    input  in_yumi_o, returning_v_o, returning_data_o, err_o
  );

  modport slave (
    input  in_v_i, in_we_i, in_addr_i, in_data_i, in_mask_i, in_amo_op_i,
    output in_yumi_o, returning_v_o, returning_data_o, err_o
  );
endinterface

// File: rtl/bsg_manycore_mem_responder.sv
// Word-addressed scratchpad responder: loads, byte-masked stores, swap/add/or AMOs,
// one request at a time, one-cycle response, sticky out-of-range flag.
module bsg_manycore_mem_responder #(
  parameter  int data_width_p = 32,
  parameter  int addr_width_p = 28,
  parameter  int mem_els_p    = 1024,
  localparam int idx_width_lp = $clog2(mem_els_p)
) (
  input logic                          clk_i,
  input logic                          reset_i,
  bsg_manycore_mem_responder_if.slave  bus
);

  typedef enum logic {IDLE, AMO_WR} state_e;

  state_e                  state_q, state_d;
  logic                    rsp_v_q, rsp_v_d;
  logic                    rsp_src_q, rsp_src_d;
  logic [data_width_p-1:0] rsp_data_q, rsp_data_d;
  logic                    err_q, err_d;

  logic [data_width_p-1:0] mem [mem_els_p];
  logic [data_width_p-1:0] sram_rdata_q;

  logic [idx_width_lp-1:0] idx;
  logic                    oor;
  logic                    yumi;
  logic                    rd_en, wr_en;
  logic [3:0]              wr_be;
  logic [data_width_p-1:0] wr_data;
  logic [data_width_p-1:0] amo_new;
  logic [data_width_p-1:0] ret_data;

  assign idx = bus.in_addr_i[idx_width_lp-1:0];
  assign oor = |bus.in_addr_i[addr_width_p-1:idx_width_lp];

  // Load responses come straight from the SRAM output register; every other cycle
  // the output register re-captures what is shown, so the data holds while idle
  // even when an AMO read later overwrites the SRAM output.
  assign ret_data = rsp_src_q ? sram_rdata_q : rsp_data_q;

  always_comb begin
    unique case (bus.in_amo_op_i)
      2'd1:    amo_new = bus.in_data_i;
      2'd2:    amo_new = sram_rdata_q + bus.in_data_i;
      default: amo_new = sram_rdata_q | bus.in_data_i;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    yumi       = 1'b0;
    rd_en      = 1'b0;
    wr_en      = 1'b0;
    wr_be      = '0;
    wr_data    = bus.in_data_i;
    rsp_v_d    = 1'b0;
    rsp_src_d  = 1'b0;
    rsp_data_d = ret_data;
    err_d      = err_q;
    if (reset_i) begin
      unique case (state_q)
        IDLE: begin
          if (bus.in_v_i) begin
            if (oor) begin
              yumi       = 1'b1;
              rsp_v_d    = 1'b1;
              rsp_data_d = 32'hDEAD_BEEF;
              err_d      = 1'b1;
            end else if (bus.in_amo_op_i != 2'd0) begin
              rd_en   = 1'b1;
              state_d = AMO_WR;
            end else if (bus.in_we_i) begin
              yumi       = 1'b1;
              wr_en      = 1'b1;
              wr_be      = bus.in_mask_i;
              rsp_v_d    = 1'b1;
              rsp_data_d = '0;
            end else begin
              yumi      = 1'b1;
              rd_en     = 1'b1;
              rsp_v_d   = 1'b1;
              rsp_src_d = 1'b1;
            end
          end
        end
        AMO_WR: begin
          yumi       = 1'b1;
          wr_en      = 1'b1;
          wr_be      = '1;
          wr_data    = amo_new;
          rsp_v_d    = 1'b1;
          rsp_data_d = sram_rdata_q;
          state_d    = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rd_en) sram_rdata_q <= mem[idx];
    if (wr_en) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (wr_be[b]) mem[idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q    <= IDLE;
      rsp_v_q    <= 1'b0;
      rsp_src_q  <= 1'b0;
      rsp_data_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rsp_v_q    <= rsp_v_d;
      rsp_src_q  <= rsp_src_d;
      rsp_data_q <= rsp_data_d;
      err_q      <= err_d;
    end
  end

  assign bus.in_yumi_o        = yumi;
  assign bus.returning_v_o    = rsp_v_q;
  assign bus.returning_data_o = ret_data;
  assign bus.err_o            = err_q;

endmodule

// File: tb/tb_bsg_manycore_mem_responder.sv
// Directed bench for bsg_manycore_mem_responder with a word-array memory model
// and a per-cycle response/err/hold checker.
module tb_bsg_manycore_mem_responder;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  bsg_manycore_mem_responder_if #(.addr_width_p(28), .data_width_p(32)) bus ();

  bsg_manycore_mem_responder #(
    .data_width_p(32),
    .addr_width_p(28),
    .mem_els_p(1024)
  ) dut (
    .clk_i  (clk),
    .reset_i(reset_n),
    .bus    (bus)
  );

  typedef struct {
    int          due;
    logic [31:0] data;
    logic [31:0] lit;
  } rsp_t;

  rsp_t        q[$];
  logic [31:0] mm [1024];
  logic [31:0] last_data = '0;
  bit          err_set = 1'b0;
  int          err_from = 0;
  int          cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // Per-cycle checker of the response path against the model queue.
  always @(negedge clk) begin
    if (!reset_n) begin
      chk("reset_ret_v", {31'b0, bus.returning_v_o}, 32'd0);
      chk("reset_ret_data", bus.returning_data_o, 32'd0);
      chk("reset_err", {31'b0, bus.err_o}, 32'd0);
    end else begin
      if (q.size() > 0 && q[0].due == cyc) begin
        rsp_t e;
        e = q.pop_front();
        chk("ret_v", {31'b0, bus.returning_v_o}, 32'd1);
        chk("ret_data", bus.returning_data_o, e.data);
        chk("ret_data_literal", bus.returning_data_o, e.lit);
        last_data = e.data;
      end else begin
        chk("ret_v_idle", {31'b0, bus.returning_v_o}, 32'd0);
        chk("ret_data_hold", bus.returning_data_o, last_data);
      end
      chk("err", {31'b0, bus.err_o}, {31'b0, err_set && (cyc >= err_from)});
    end
  end

  // Called #1 after a posedge; returns #1 after the posedge ending the request.
  task automatic req(input bit we, input bit [1:0] amo, input int unsigned addr,
                     input bit [31:0] d, input bit [3:0] m, input bit [31:0] lit);
    bit          oor;
    int unsigned i;
    logic [31:0] old;
    logic [31:0] exp;
    oor = (addr >= 1024);
    i   = addr % 1024;
    bus.in_v_i      = 1'b1;
    bus.in_we_i     = we;
    bus.in_amo_op_i = amo;
    bus.in_addr_i   = 28'(addr);
    bus.in_data_i   = d;
    bus.in_mask_i   = m;
    if (oor) begin
      exp = 32'hDEAD_BEEF;
      if (!err_set) begin
        err_set  = 1'b1;
        err_from = cyc + 1;
      end
    end else if (amo != 2'd0) begin
      old = mm[i];
      case (amo)
        2'd1:    mm[i] = d;
        2'd2:    mm[i] = old + d;
        default: mm[i] = old | d;
      endcase
      exp = old;
    end else if (we) begin
      for (int b = 0; b < 4; b++) if (m[b]) mm[i][8*b +: 8] = d[8*b +: 8];
      exp = '0;
    end else begin
      exp = mm[i];
    end
    if (amo != 2'd0 && !oor) begin
      @(negedge clk);
      chk("amo_yumi_wait", {31'b0, bus.in_yumi_o}, 32'd0);
      @(posedge clk); #1;
    end
    q.push_back('{cyc + 1, exp, lit});
    @(negedge clk);
    chk("yumi", {31'b0, bus.in_yumi_o}, 32'd1);
    @(posedge clk); #1;
    bus.in_v_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bus.in_v_i = 1'b1;
    bus.in_we_i = 1'b0;
    bus.in_amo_op_i = 2'd0;
    bus.in_addr_i = '0;
    bus.in_data_i = '0;
    bus.in_mask_i = '0;
    repeat (2) @(posedge clk);
    #1 chk("reset_yumi", {31'b0, bus.in_yumi_o}, 32'd0);
    @(posedge clk); #1;
    bus.in_v_i = 1'b0;
    reset_n = 1'b1;

    // store then back-to-back load
    req(1'b1, 2'd0, 5, 32'h1234_5678, 4'b1111, 32'h0);
    req(1'b0, 2'd0, 5, 32'h0, 4'b0000, 32'h1234_5678);
    // byte mask
    req(1'b1, 2'd0, 5, 32'hAABB_CCDD, 4'b0101, 32'h0);
    req(1'b0, 2'd0, 5, 32'h0, 4'b0000, 32'h12BB_56DD);
    // AMO add with wrap
    req(1'b1, 2'd0, 7, 32'hFFFF_FFFF, 4'b1111, 32'h0);
    req(1'b0, 2'd2, 7, 32'h2, 4'b0000, 32'hFFFF_FFFF);
    req(1'b0, 2'd0, 7, 32'h0, 4'b0000, 32'h0000_0001);
    // AMO swap / or, store flag ignored on the swap
    req(1'b1, 2'd0, 3, 32'h0F0F_0000, 4'b1111, 32'h0);
    req(1'b1, 2'd1, 3, 32'h1, 4'b0001, 32'h0F0F_0000);
    req(1'b0, 2'd3, 3, 32'h10, 4'b0000, 32'h1);
    req(1'b0, 2'd0, 3, 32'h0, 4'b0000, 32'h11);
    // out of range: load, store, AMO; mem[0] untouched
    req(1'b1, 2'd0, 0, 32'hCAFE_F00D, 4'b1111, 32'h0);
    req(1'b0, 2'd0, 1024, 32'h0, 4'b0000, 32'hDEAD_BEEF);
    req(1'b1, 2'd0, 1024, 32'h0, 4'b1111, 32'hDEAD_BEEF);
    req(1'b0, 2'd2, 1029, 32'h1, 4'b0000, 32'hDEAD_BEEF);
    req(1'b0, 2'd0, 0, 32'h0, 4'b0000, 32'hCAFE_F00D);
    req(1'b0, 2'd0, 1023, 32'h0, 4'b0000, mm[1023]);
    repeat (3) @(posedge clk);
    #1;

    // reset during AMO_WR
    req(1'b1, 2'd0, 9, 32'd5, 4'b1111, 32'h0);
    bus.in_v_i = 1'b1;
    bus.in_we_i = 1'b0;
    bus.in_amo_op_i = 2'd2;
    bus.in_addr_i = 28'd9;
    bus.in_data_i = 32'd1;
    @(negedge clk);
    chk("rst_amo_yumi_wait", {31'b0, bus.in_yumi_o}, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b0;
    err_set = 1'b0;
    last_data = '0;
    #1 chk("rst_mid_amo_yumi", {31'b0, bus.in_yumi_o}, 32'd0);
    chk("rst_queue_empty", q.size(), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    bus.in_v_i = 1'b0;
    bus.in_amo_op_i = 2'd0;
    reset_n = 1'b1;
    req(1'b0, 2'd0, 9, 32'h0, 4'b0000, 32'd5);

    repeat (3) @(posedge clk);
    #1 chk("final_queue_empty", q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
